// File: rtl/pipe_stage_chain.sv
`timescale 1ns/1ps
// pipe_stage_chain
// Generic chain of DEPTH pipeline registers, each carrying a payload and a
// valid bit. It replaces the separate IF/ID, ID/EX, EX/MEM and MEM/WB
// boundary registers. The hazard unit drives the per-stage stall and flush
// controls. Stage 0 is the youngest stage. Stage DEPTH-1 drives out_*.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   in_data      payload entering stage 0
//   in_valid     in_data is a real instruction
//   in_accept    stage 0 takes the input this edge (combinational)
//   stall        per-stage hold request, bit i = stage i
//   flush        per-stage kill request, bit i = stage i
//   kill_clr     synchronous clear of kill_count
//   stage_data   all stage payloads, stage i at [i*DATA_W +: DATA_W]
//   stage_valid  valid bit per stage
//   out_data     payload of the oldest stage
//   out_valid    valid bit of the oldest stage
//   occupancy    number of valid stages
//   kill_count   valid entries destroyed by flush, saturating
module pipe_stage_chain #(
  parameter int                DATA_W        = 32,
  parameter int                DEPTH         = 4,
  parameter int                AUTO_STALL    = 1,
  parameter int                CLEAR_PAYLOAD = 1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL    = '0,
  parameter int                CNT_W         = 16,
  localparam int               OCC_W         = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_accept,
  input  logic [DEPTH-1:0]        stall,
  input  logic [DEPTH-1:0]        flush,
  input  logic                    kill_clr,
  output logic [DEPTH*DATA_W-1:0] stage_data,
  output logic [DEPTH-1:0]        stage_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  output logic [OCC_W-1:0]        occupancy,
  output logic [CNT_W-1:0]        kill_count
);

  logic [DEPTH-1:0]  stall_eff;
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic              valid_q [DEPTH];
  logic [OCC_W-1:0]  kills;
  logic [CNT_W:0]    kill_sum;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic              bubble_req;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;

    // With AUTO_STALL, a stall on any older stage also freezes this stage.
    // Younger entries therefore cannot run into a held stage.
    assign stall_eff[i] = (AUTO_STALL != 0) ? |stall[DEPTH-1:i] : stall[i];

    // A stage starts a bubble when the stage feeding it is held and this
    // stage is free to move. Stage 0 has no feeder inside the chain.
    if (i == 0) begin : g_head
      assign bubble_req = 1'b0;
      assign load_valid = in_valid;
      assign load_data  = in_data;
    end else begin : g_body
      assign bubble_req = stall_eff[i-1];
      assign load_valid = valid_q[i-1];
      assign load_data  = data_q[i-1];
    end

    // The priority order is flush, then hold, then bubble, then load.
    // Flush must beat stall on the same stage. A hold must beat a bubble
    // when both stall bits are set without AUTO_STALL.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= BUBBLE_VAL;
      end else if (flush[i]) begin
        valid_q[i] <= 1'b0;
        if (CLEAR_PAYLOAD != 0) data_q[i] <= BUBBLE_VAL;
      end else if (stall_eff[i]) begin
        valid_q[i] <= valid_q[i];
        data_q[i]  <= data_q[i];
      end else if (bubble_req) begin
        valid_q[i] <= 1'b0;
        if (CLEAR_PAYLOAD != 0) data_q[i] <= BUBBLE_VAL;
      end else begin
        valid_q[i] <= load_valid;
        data_q[i]  <= load_data;
      end
    end

    assign stage_data[i*DATA_W +: DATA_W] = data_q[i];
    assign stage_valid[i]                 = valid_q[i];
  end

  assign in_accept = ~stall_eff[0] & ~flush[0];
  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];

  // Count the valid stages, and count only the flushed stages that were valid.
  always_comb begin
    occupancy = '0;
    kills     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(stall_eff[i] & 1'b0) + OCC_W'(stage_valid[i]);
      kills     = kills + OCC_W'(flush[i] & stage_valid[i]);
    end
  end

  assign kill_sum = {1'b0, kill_count} + (CNT_W+1)'(kills);

  // The extra sum bit detects overflow, and the counter then holds at all-ones.
  // kill_clr beats a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kill_count <= '0;
    end else if (kill_clr) begin
      kill_count <= '0;
    end else if (kill_sum[CNT_W]) begin
      kill_count <= '1;
    end else begin
      kill_count <= kill_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
`timescale 1ns/1ps
// tb_pipe_stage_chain
// Directed bench for pipe_stage_chain with DEPTH=4 and DATA_W=32.
// u_dut uses AUTO_STALL=1 and u_dut_ns uses AUTO_STALL=0.
// Both instances share the same inputs.
// Expected values are worked out by hand from the stage priority rules.
module tb_pipe_stage_chain;

  logic         clk;
  logic         reset_n;
  logic [31:0]  in_data;
  logic         in_valid;
  logic [3:0]   stall;
  logic [3:0]   flush;
  logic         kill_clr;

  logic         in_accept;
  logic [127:0] stage_data;
  logic [3:0]   stage_valid;
  logic [31:0]  out_data;
  logic         out_valid;
  logic [2:0]   occupancy;
  logic [15:0]  kill_count;

  logic         ns_in_accept;
  logic [127:0] ns_stage_data;
  logic [3:0]   ns_stage_valid;
  logic [31:0]  ns_out_data;
  logic         ns_out_valid;
  logic [2:0]   ns_occupancy;
  logic [15:0]  ns_kill_count;

  int assert_count = 0;
  int fail_count   = 0;

  pipe_stage_chain #(
    .DATA_W(32), .DEPTH(4), .AUTO_STALL(1), .CLEAR_PAYLOAD(1),
    .BUBBLE_VAL(32'h0), .CNT_W(16)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_accept(in_accept), .stall(stall), .flush(flush), .kill_clr(kill_clr),
    .stage_data(stage_data), .stage_valid(stage_valid), .out_data(out_data),
    .out_valid(out_valid), .occupancy(occupancy), .kill_count(kill_count)
  );

  pipe_stage_chain #(
    .DATA_W(32), .DEPTH(4), .AUTO_STALL(0), .CLEAR_PAYLOAD(1),
    .BUBBLE_VAL(32'h0), .CNT_W(16)
  ) u_dut_ns (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_accept(ns_in_accept), .stall(stall), .flush(flush), .kill_clr(kill_clr),
    .stage_data(ns_stage_data), .stage_valid(ns_stage_valid), .out_data(ns_out_data),
    .out_valid(ns_out_valid), .occupancy(ns_occupancy), .kill_count(ns_kill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stop the run if it ever stops advancing.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the inputs, then wait 1 ns so the combinational outputs settle.
  task automatic applyStimulus(input logic [31:0] d, input logic v,
                               input logic [3:0] st, input logic [3:0] fl,
                               input logic kc);
    in_data  = d;
    in_valid = v;
    stall    = st;
    flush    = fl;
    kill_clr = kc;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut;
    applyStimulus(32'h0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    reset_n = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
  endtask

  task automatic fillPipe;
    applyStimulus(32'h11, 1'b1, 4'b0000, 4'b0000, 1'b0); tick;
    applyStimulus(32'h22, 1'b1, 4'b0000, 4'b0000, 1'b0); tick;
    applyStimulus(32'h33, 1'b1, 4'b0000, 4'b0000, 1'b0); tick;
    applyStimulus(32'h44, 1'b1, 4'b0000, 4'b0000, 1'b0); tick;
  endtask

  initial begin
    reset_n  = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    stall    = '0;
    flush    = '0;
    kill_clr = 1'b0;

    // Check the reset state.
    resetDut;
    checkOutput("reset_valid", 128'(stage_valid), 128'h0);
    checkOutput("reset_data", stage_data, 128'h0);
    checkOutput("reset_occ", 128'(occupancy), 128'h0);
    checkOutput("reset_kill", 128'(kill_count), 128'h0);
    checkOutput("reset_accept", 128'(in_accept), 128'h1);

    // Stream four valid words with no stall.
    applyStimulus(32'h11, 1'b1, 4'b0000, 4'b0000, 1'b0); tick;
    applyStimulus(32'h22, 1'b1, 4'b0000, 4'b0000, 1'b0); tick;
    applyStimulus(32'h33, 1'b1, 4'b0000, 4'b0000, 1'b0); tick;
    checkOutput("stream_e3_out_valid", 128'(out_valid), 128'h0);
    checkOutput("stream_e3_occ", 128'(occupancy), 128'h3);
    applyStimulus(32'h44, 1'b1, 4'b0000, 4'b0000, 1'b0); tick;
    checkOutput("stream_out_data", 128'(out_data), 128'h11);
    checkOutput("stream_out_valid", 128'(out_valid), 128'h1);
    checkOutput("stream_occ", 128'(occupancy), 128'h4);
    checkOutput("stream_stage_data", stage_data,
                {32'h11, 32'h22, 32'h33, 32'h44});

    // stall[2] for two cycles: s0..s2 hold and s3 becomes a bubble.
    for (int c = 0; c < 2; c++) begin
      applyStimulus(32'h55, 1'b1, 4'b0100, 4'b0000, 1'b0);
      checkOutput("stall2_accept", 128'(in_accept), 128'h0);
      tick;
      checkOutput("stall2_data", stage_data, {32'h0, 32'h22, 32'h33, 32'h44});
      checkOutput("stall2_valid", 128'(stage_valid), 128'h7);
    end
    checkOutput("stall2_occ", 128'(occupancy), 128'h3);
    checkOutput("stall2_kill", 128'(kill_count), 128'h0);

    // flush[1] and stall[1] on the same edge.
    resetDut;
    fillPipe;
    applyStimulus(32'h55, 1'b1, 4'b0010, 4'b0010, 1'b0);
    checkOutput("fl1st1_accept", 128'(in_accept), 128'h0);
    tick;
    checkOutput("fl1st1_data", stage_data, {32'h22, 32'h0, 32'h0, 32'h44});
    checkOutput("fl1st1_valid", 128'(stage_valid), 128'h9);
    checkOutput("fl1st1_kill", 128'(kill_count), 128'h1);

    // flush 0011 with s0 valid and s1 a bubble adds one kill.
    applyStimulus(32'h66, 1'b1, 4'b0000, 4'b0011, 1'b0);
    checkOutput("fl0011_accept", 128'(in_accept), 128'h0);
    tick;
    checkOutput("fl0011_kill", 128'(kill_count), 128'h2);
    checkOutput("fl0011_valid", 128'(stage_valid), 128'h0);

    // kill_clr beats a same-cycle kill of a valid s3.
    fillPipe;
    checkOutput("refill_kill", 128'(kill_count), 128'h2);
    applyStimulus(32'h77, 1'b1, 4'b0000, 4'b1000, 1'b1);
    tick;
    checkOutput("clr_kill", 128'(kill_count), 128'h0);
    checkOutput("clr_valid", 128'(stage_valid), 128'h7);

    // Flush alternating stage pairs, two valid kills per edge, to reach saturation.
    for (int n = 0; n < 32767; n++) begin
      applyStimulus(n, 1'b1, 4'b0000, (n % 2 == 0) ? 4'b0101 : 4'b1010, 1'b0);
      tick;
    end
    checkOutput("sat_pre_kill", 128'(kill_count), 128'hFFFE);
    applyStimulus(32'hAA, 1'b1, 4'b0000, 4'b1010, 1'b0);
    tick;
    checkOutput("sat_kill", 128'(kill_count), 128'hFFFF);
    applyStimulus(32'hBB, 1'b1, 4'b0000, 4'b0101, 1'b0);
    tick;
    checkOutput("sat_hold_kill", 128'(kill_count), 128'hFFFF);

    // Assert reset between edges. Its effect must not wait for a clock.
    applyStimulus(32'hCC, 1'b1, 4'b0000, 4'b0000, 1'b0);
    tick;
    checkOutput("pre_async_occ", 128'(occupancy), 128'h2);
    reset_n = 1'b0;
    #1;
    checkOutput("async_valid", 128'(stage_valid), 128'h0);
    checkOutput("async_data", stage_data, 128'h0);
    checkOutput("async_kill", 128'(kill_count), 128'h0);
    tick;
    reset_n = 1'b1;

    // Without AUTO_STALL, stall 0100 holds only s2. s1 is overwritten.
    fillPipe;
    applyStimulus(32'h55, 1'b1, 4'b0100, 4'b0000, 1'b0);
    checkOutput("ns_accept", 128'(ns_in_accept), 128'h1);
    tick;
    checkOutput("ns_data", ns_stage_data, {32'h0, 32'h22, 32'h44, 32'h55});
    checkOutput("ns_valid", 128'(ns_stage_valid), 128'h7);
    checkOutput("ns_out_valid", 128'(ns_out_valid), 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
